// File: rtl/keypad_scan_ctrl_if.sv
// rtl/keypad_scan_ctrl_if.sv - keypad matrix and key-report signal bundle
interface keypad_scan_ctrl_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       held;

  // Controller side: reads the raw columns, drives rows and key reports.
  modport slave (
    input  col,
    output row, key_code, key_valid, digit_new, digit_old, held
  );

  // Keypad / consumer side.
  modport master (
    output col,
    input  row, key_code, key_valid, digit_new, digit_old, held
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad row scanner with debounce and two-digit history
module keypad_scan_ctrl #(
  parameter int DWELL    = 500,
  parameter int DEBOUNCE = 20000
) (
  input  logic                 clk,
  input  logic                 reset,
  keypad_scan_ctrl_if.slave    kp
);

  localparam int DW  = $clog2(DWELL);
  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL - 1);
  localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      col_meta, cs;
  logic [1:0]      row_idx, row_idx_nxt;
  logic [DW-1:0]   dwell_cnt, dwell_nxt;
  logic [DBW-1:0]  deb_cnt, deb_nxt;
  logic [1:0]      lat_row, lat_col_idx, col_idx;
  logic [3:0]      lat_col;
  logic [3:0]      active_low;
  logic            one_low, key_bit, latch_en, accept;
  logic [3:0]      code;

  assign active_low = ~cs;
  // A single pressed column in the active row; anything else is idle or ghosting.
  assign one_low    = (active_low != 4'd0) && ((active_low & (active_low - 4'd1)) == 4'd0);
  assign key_bit    = cs[lat_col_idx];

  // Encode the single low column to its index for latching.
  always_comb begin
    col_idx = 2'd0;
    case (active_low)
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Keypad legend lookup for the latched row/column.
  always_comb begin
    code = 4'h0;
    case ({lat_row, lat_col_idx})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
  end

  // Next-state and counter control; all decisions use the synchronized columns.
  always_comb begin
    state_nxt   = state;
    row_idx_nxt = row_idx;
    dwell_nxt   = dwell_cnt;
    deb_nxt     = deb_cnt;
    latch_en    = 1'b0;
    accept      = 1'b0;
    case (state)
      ST_SCAN: begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_nxt = '0;
          if (one_low) begin
            latch_en  = 1'b1;
            deb_nxt   = '0;
            state_nxt = ST_DEBOUNCE;
          end else begin
            row_idx_nxt = row_idx + 2'd1;
          end
        end else begin
          dwell_nxt = dwell_cnt + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (cs == lat_col) begin
          if (deb_cnt == DEB_LAST) begin
            state_nxt = ST_HELD;
            accept    = 1'b1;
            deb_nxt   = '0;
          end else begin
            deb_nxt = deb_cnt + 1'b1;
          end
        end else begin
          state_nxt   = ST_SCAN;
          row_idx_nxt = row_idx + 2'd1;
          dwell_nxt   = '0;
        end
      end
      ST_HELD: begin
        // Only the latched contact matters; rollover keys are ignored here.
        if (key_bit) begin
          state_nxt = ST_RELEASE;
          deb_nxt   = '0;
        end
      end
      ST_RELEASE: begin
        if (!key_bit) begin
          state_nxt = ST_HELD;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = ST_SCAN;
          row_idx_nxt = row_idx + 2'd1;
          dwell_nxt   = '0;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_SCAN;
        dwell_nxt = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_SCAN;
    else        state <= state_nxt;
  end

  // Column synchronizer, counters, latched key and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_meta     <= 4'hF;
      cs           <= 4'hF;
      row_idx      <= 2'd0;
      dwell_cnt    <= '0;
      deb_cnt      <= '0;
      lat_row      <= 2'd0;
      lat_col      <= 4'd0;
      lat_col_idx  <= 2'd0;
      kp.row       <= 4'b1110;
      kp.key_code  <= 4'd0;
      kp.key_valid <= 1'b0;
      kp.digit_new <= 4'd0;
      kp.digit_old <= 4'd0;
      kp.held      <= 1'b0;
    end else begin
      col_meta     <= kp.col;
      cs           <= col_meta;
      row_idx      <= row_idx_nxt;
      dwell_cnt    <= dwell_nxt;
      deb_cnt      <= deb_nxt;
      kp.row       <= ~(4'b0001 << row_idx_nxt);
      kp.key_valid <= accept;
      kp.held      <= (state_nxt == ST_HELD) || (state_nxt == ST_RELEASE);
      if (latch_en) begin
        lat_row     <= row_idx;
        lat_col     <= cs;
        lat_col_idx <= col_idx;
      end
      if (accept) begin
        kp.key_code  <= code;
        kp.digit_old <= kp.digit_new;
        kp.digit_new <= code;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - scoreboard bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] pressed = 16'h0;
  logic [3:0] kcol;

  int compared = 0;
  int mismatched = 0;
  int strobes = 0;
  logic prev_valid = 1'b0;

  typedef struct packed {
    logic [3:0] code;
    logic [3:0] dnew;
    logic [3:0] dold;
  } exp_t;
  exp_t exp_q[$];

  keypad_scan_ctrl_if kif();

  keypad_scan_ctrl #(.DWELL(4), .DEBOUNCE(8)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    kcol = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.row[r]) kcol[c] = 1'b0;
  end
  assign kif.col = kcol;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_strobe(input int budget);
    int s0 = strobes;
    int n = 0;
    while (strobes == s0 && n < budget) begin
      tick(1);
      n++;
    end
    check("strobe_wait", 32'(strobes != s0), 32'd1);
  endtask

  task automatic wait_row(input logic [3:0] val, input int budget);
    int n = 0;
    while (kif.row !== val && n < budget) begin
      tick(1);
      n++;
    end
    check("row_wait", 32'(kif.row), 32'(val));
  endtask

  task automatic wait_held(input logic val, input int budget);
    int n = 0;
    while (kif.held !== val && n < budget) begin
      tick(1);
      n++;
    end
    check("held_wait", 32'(kif.held), 32'(val));
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (kif.key_valid) begin
      exp_t e;
      strobes++;
      check("valid_back_to_back", 32'(prev_valid), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("key_code", 32'(kif.key_code), 32'(e.code));
        check("digit_new", 32'(kif.digit_new), 32'(e.dnew));
        check("digit_old", 32'(kif.digit_old), 32'(e.dold));
        check("held_at_strobe", 32'(kif.held), 32'd1);
      end
    end
    prev_valid = kif.key_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_before;

    // 1. Reset values and idle scan rotation.
    tick(3);
    check("rst_row", 32'(kif.row), 32'hE);
    check("rst_valid", 32'(kif.key_valid), 32'd0);
    check("rst_code", 32'(kif.key_code), 32'd0);
    check("rst_dnew", 32'(kif.digit_new), 32'd0);
    check("rst_dold", 32'(kif.digit_old), 32'd0);
    check("rst_held", 32'(kif.held), 32'd0);
    reset = 1'b1;
    tick(3);  check("scan_r0_hold", 32'(kif.row), 32'hE);
    tick(1);  check("scan_r1", 32'(kif.row), 32'hD);
    tick(4);  check("scan_r2", 32'(kif.row), 32'hB);
    tick(4);  check("scan_r3", 32'(kif.row), 32'h7);
    tick(4);  check("scan_wrap", 32'(kif.row), 32'hE);

    // 2. Clean press of '5' with exact strobe and release timing.
    pressed[5] = 1'b1;
    exp_q.push_back('{code: 4'h5, dnew: 4'h5, dold: 4'h0});
    wait_row(4'hD, 10);
    tick(11);
    check("pre_strobe_valid", 32'(kif.key_valid), 32'd0);
    check("pre_strobe_held", 32'(kif.held), 32'd0);
    tick(1);
    check("strobe_valid", 32'(kif.key_valid), 32'd1);
    check("strobe_row_frozen", 32'(kif.row), 32'hD);
    tick(20);
    check("hold_row", 32'(kif.row), 32'hD);
    check("hold_held", 32'(kif.held), 32'd1);
    pressed[5] = 1'b0;
    tick(10);
    check("release_held_on", 32'(kif.held), 32'd1);
    tick(1);
    check("release_held_off", 32'(kif.held), 32'd0);
    check("release_row_next", 32'(kif.row), 32'hB);

    // 3. Short press glitches, then a stable press with a re-closure during release.
    s_before = strobes;
    for (int i = 0; i < 10; i++) begin
      pressed[5] = 1'b1; tick(3);
      pressed[5] = 1'b0; tick(3);
    end
    check("glitch_no_strobe", 32'(strobes), 32'(s_before));
    pressed[5] = 1'b1;
    exp_q.push_back('{code: 4'h5, dnew: 4'h5, dold: 4'h5});
    wait_strobe(100);
    tick(5);
    pressed[5] = 1'b0; tick(4);
    pressed[5] = 1'b1; tick(3);
    pressed[5] = 1'b0;
    check("reclose_held", 32'(kif.held), 32'd1);
    tick(10);
    check("reclose_release_held_on", 32'(kif.held), 32'd1);
    tick(1);
    check("reclose_release_held_off", 32'(kif.held), 32'd0);
    check("reclose_single_strobe", 32'(strobes), 32'(s_before + 1));

    // 4. Rollover: 'A' pressed while '5' held, reported after '5' is released.
    wait_row(4'hE, 20);
    pressed[5] = 1'b1;
    exp_q.push_back('{code: 4'h5, dnew: 4'h5, dold: 4'h5});
    wait_strobe(100);
    s_before = strobes;
    pressed[3] = 1'b1;
    tick(30);
    check("rollover_no_strobe", 32'(strobes), 32'(s_before));
    check("rollover_row_frozen", 32'(kif.row), 32'hD);
    exp_q.push_back('{code: 4'hA, dnew: 4'hA, dold: 4'h5});
    pressed[5] = 1'b0;
    wait_strobe(200);
    check("rollover_row_a", 32'(kif.row), 32'hE);
    pressed[3] = 1'b0;
    wait_held(1'b0, 50);

    // 5. Two keys on one row: ghost pattern is skipped.
    wait_row(4'hE, 20);
    s_before = strobes;
    pressed[4] = 1'b1;
    pressed[5] = 1'b1;
    wait_row(4'hD, 10);
    tick(3);
    check("ghost_row_dwell", 32'(kif.row), 32'hD);
    tick(1);
    check("ghost_row_advance", 32'(kif.row), 32'hB);
    check("ghost_held", 32'(kif.held), 32'd0);
    tick(40);
    check("ghost_no_strobe", 32'(strobes), 32'(s_before));
    check("ghost_held_late", 32'(kif.held), 32'd0);
    pressed[4] = 1'b0;
    pressed[5] = 1'b0;

    // 6. Reset in the middle of debouncing '9'.
    wait_row(4'hE, 20);
    pressed[10] = 1'b1;
    wait_row(4'hB, 20);
    tick(3);
    tick(4);
    check("mid_deb_row", 32'(kif.row), 32'hB);
    check("mid_deb_valid", 32'(kif.key_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("abort_row", 32'(kif.row), 32'hE);
    check("abort_held", 32'(kif.held), 32'd0);
    check("abort_valid", 32'(kif.key_valid), 32'd0);
    check("abort_code", 32'(kif.key_code), 32'd0);
    check("abort_dnew", 32'(kif.digit_new), 32'd0);
    check("abort_dold", 32'(kif.digit_old), 32'd0);
    pressed[10] = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(100);
    check("post_abort_strobes", 32'(strobes), 32'd4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Sequences the 4x4 matrix keypad. It drives one row low at a time, synchronizes and debounces the column inputs, and registers exactly one press per physical key actuation. It emits a one-cycle strobe with the decoded hex code and maintains a two-digit history (newest/previous) for the dual seven-segment display path.

Parameters:
DWELL, 500, clock cycles each row is driven before its column sample; min 3.
DEBOUNCE, 20000, consecutive stable cycles required to accept a press or a release; min 1.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
col  input  4  raw keypad columns, active-low (pulled up), asynchronous to clk.
row  output  4  keypad rows, active-low, one-hot-low; only one row is low at any time.
key_code  output  4  hex code of the last accepted key.
key_valid  output  1  one-cycle strobe marking acceptance of a new key.
digit_new  output  4  most recently accepted key.
digit_old  output  4  key accepted before digit_new.
held  output  1  high while the accepted key is held or its release is being debounced.

Behaviour:
- Column synchronizer: a 2-flop synchronizer on col. All FSM decisions use the synchronized value (cs) only. Latency is 2 cycles.
- Key map (row r, col c -> code):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- Reset (reset=0, immediate):
  - state=SCAN, row index=0, so row=4'b1110.
  - dwell and debounce counters=0.
  - key_code=0, key_valid=0, digit_new=0, digit_old=0, held=0.
  - Latched row/col cleared.
- SCAN:
  - The dwell counter counts 0..DWELL-1 on the current row.
  - At count DWELL-1, sample cs:
    - Exactly one bit low: latch the row index and one-hot col, clear the debounce counter, go to DEBOUNCE. The row stays frozen.
    - Zero bits low, or two or more bits low: advance the row index (3 wraps to 0) and reset the dwell counter.
- DEBOUNCE:
  - The row is held.
  - Each cycle cs equals the latched pattern: increment the counter.
  - Any mismatch: go to SCAN, advance the row, clear the dwell counter.
  - Counter reaches DEBOUNCE-1 with a match: go to HELD.
- Acceptance, registered on entry to HELD:
  - key_valid=1 for exactly that one cycle.
  - key_code=code, digit_old<=digit_new, digit_new<=code.
  - Strobe timing: key_valid is high at cycle T+1+DEBOUNCE, where T is the sample cycle.
- HELD:
  - The row is held and held=1.
  - The FSM stays while the latched col bit is low. Other column bits are ignored, so additional keys produce no strobe.
  - Latched bit high: go to RELEASE and clear the counter.
- RELEASE:
  - held=1.
  - Latched bit low again (bounce): return to HELD with no new strobe.
  - Bit high for DEBOUNCE consecutive cycles: go to SCAN with the row advanced and held=0.
- Illegal or unused state encodings go to SCAN.
- key_valid is never asserted in two consecutive cycles.
- Reset asserted in any state aborts the operation. No strobe occurs after deassertion until a full new press and debounce complete.
- All outputs are registered; none are combinational from col.

Test Plan:
1. Reset check, DWELL=4, DEBOUNCE=8: hold reset low for 3 cycles then release. Required: row=1110, key_valid=0, key_code=0, digit_new=0, digit_old=0, held=0. Row then cycles 1110 -> 1101 -> 1011 -> 0111 every 4 cycles with col=1111.
2. Clean press: model '5' as row1/col1, so col[1]=0 whenever row=1101, and hold it. Required: exactly one key_valid pulse, key_code=5, digit_new=5, digit_old=0, held=1, row frozen at 1101. After col returns high for ≥8 cycles: held=0 and scanning resumes at row 1011.
3. Bounce: toggle the '5' contact with press glitches shorter than 8 cycles. Required: no key_valid. Then hold it stable. Required: one strobe. During release, inject a 3-cycle re-closure. Required: return to HELD, no second strobe.
4. Rollover: hold '5' and add 'A' (row0/col3). Required: no strobe while '5' is held. Release '5' with 'A' still held. Required: after release debounce, 'A' is found; key_valid pulse with key_code=A, digit_new=A, digit_old=5.
5. Ghost/multi-key: '4' and '5' (row1, col0 and col1) both low at the sample. Required: row advances, no strobe, state remains SCAN.
6. Reset mid-operation: assert reset 4 cycles into DEBOUNCE of '9'. Required: outputs return to reset values immediately. After deassertion with the key released, no key_valid occurs.
